// File: rtl/apb_slave_regbank_pkg.sv
// Shared types and helpers for the APB register-bank completer.
package apb_pkg;

  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} apb_slv_state_e;

  function automatic logic [31:0] word_idx(input logic [31:0] addr);
    return addr >> 2;
  endfunction

endpackage

// File: rtl/apb_slave_regbank_if.sv
// APB3 bus bundle between the bridge (master) and the register bank (slave).
interface apb_slave_regbank_if
  import apb_pkg::*;
#(
  parameter int ADDR_W = 8
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_W-1:0]     paddr;
  logic [APB_DATA_W-1:0] pwdata;
  logic [APB_DATA_W-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

endinterface

// File: rtl/apb_slave_regbank_reg_array.sv
// Word register storage: one synchronous write port, one combinational read port.
module apb_reg_array
  import apb_pkg::*;
#(
  parameter int NUM_REGS = 8,
  parameter int IDX_W    = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      widx_i,
  input  logic [APB_DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]      ridx_i,
  output logic [APB_DATA_W-1:0] rdata_o
);

  logic [APB_DATA_W-1:0] mem_q [NUM_REGS];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (32'(widx_i) < 32'(NUM_REGS))) begin
      mem_q[widx_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (32'(ridx_i) < 32'(NUM_REGS)) begin
      rdata_o = mem_q[ridx_i];
    end
  end

endmodule

// File: rtl/apb_slave_regbank.sv
// APB3 completer with a register bank, programmable wait states and pslverr
// reporting for misaligned, out-of-range and read-only-ID accesses.
module apb_slave_regbank
  import apb_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          ADDR_W      = 8,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA2B0_0001
) (
  input  logic                hclk,
  input  logic                hreset,
  apb_slave_regbank_if.slave  apb
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  apb_slv_state_e        state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  write_q, write_d;
  logic [APB_DATA_W-1:0] wdata_q, wdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;
  logic [APB_DATA_W-1:0] prdata_q, prdata_d;

  logic [31:0]           idx_d;
  logic                  err_d;
  logic                  id_hit_d;
  logic [IDX_W-1:0]      ridx;
  logic [APB_DATA_W-1:0] rd_word;
  logic                  we;
  logic [IDX_W-1:0]      widx;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Outputs are registered from the next state, so ACCESS is entered one edge
  // early: straight from IDLE for zero waits, else when the counter hits zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (apb.psel && !apb.penable) begin
          addr_d  = apb.paddr;
          write_d = apb.pwrite;
          wdata_d = apb.pwdata;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ACCESS : SETUP;
        end
      end
      SETUP: begin
        if (!apb.psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (apb.penable) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = (cnt_q == 4'd1) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (!apb.psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    idx_d     = word_idx(32'(addr_d));
    id_hit_d  = (idx_d == 32'(NUM_REGS - 1));
    err_d     = (addr_d[1:0] != 2'b00) || (idx_d >= 32'(NUM_REGS)) || (write_d && id_hit_d);
    ridx      = idx_d[IDX_W-1:0];
    pready_d  = (state_d == ACCESS);
    pslverr_d = pready_d && err_d;
    prdata_d  = '0;
    if (pready_d && !write_d && !err_d) begin
      prdata_d = id_hit_d ? ID_VALUE : rd_word;
    end
    we   = (state_q == ACCESS) && apb.psel && write_q && !pslverr_q;
    widx = addr_q[IDX_W+1:2];
  end

  apb_reg_array #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_regs (
    .clk_i   (hclk),
    .rst_i   (hreset),
    .we_i    (we),
    .widx_i  (widx),
    .wdata_i (wdata_q),
    .ridx_i  (ridx),
    .rdata_o (rd_word)
  );

  assign apb.pready  = pready_q;
  assign apb.pslverr = pslverr_q;
  assign apb.prdata  = prdata_q;

endmodule
